// File: rtl/aes_sbox_lane_pipe_if.sv
// rtl/aes_sbox_lane_pipe_if.sv - beat handshake bundle for aes_sbox_lane_pipe
// out_par is present only when AES_SBOX_PARITY_EN is defined.
interface aes_sbox_lane_pipe_if #(
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_mode;
  logic [8*LANES-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_mode;
  logic [8*LANES-1:0] out_data;
`ifdef AES_SBOX_PARITY_EN
  logic [LANES-1:0]   out_par;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_par
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_par
  );
`else
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );
`endif
endinterface

// File: rtl/aes_sbox_lane_pipe.sv
// rtl/aes_sbox_lane_pipe.sv - multi-lane pipelined AES forward/inverse S-box engine
// Optional per-lane even parity on the output with AES_SBOX_PARITY_EN.
module aes_sbox_lane_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  aes_sbox_lane_pipe_if.slave  bus
);

  localparam int W = 8 * LANES;

  // Entry 0x00 is the most significant byte of each table.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] idx);
    return SBOX_FWD[{~idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] idx);
    return SBOX_INV[{~idx, 3'b000} +: 8];
  endfunction

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] mode_q, mode_d;
  logic [W-1:0]      data_q [STAGES];
  logic [W-1:0]      data_d [STAGES];
  logic [STAGES-1:0] stage_ready;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_mode;
  logic [W-1:0]      src_data [STAGES];
  logic [W-1:0]      lut_data;
`ifdef AES_SBOX_PARITY_EN
  logic [LANES-1:0]  par_q [STAGES];
  logic [LANES-1:0]  par_d [STAGES];
  logic [LANES-1:0]  src_par [STAGES];
  logic [LANES-1:0]  lut_par;
`endif

  always_comb begin
    lut_data = '0;
    for (int k = 0; k < LANES; k++) begin
      lut_data[8*k +: 8] = bus.in_mode ? sbox_inv(bus.in_data[8*k +: 8])
                                       : sbox_fwd(bus.in_data[8*k +: 8]);
    end
  end

`ifdef AES_SBOX_PARITY_EN
  always_comb begin
    lut_par = '0;
    for (int k = 0; k < LANES; k++) begin
      lut_par[k] = ^lut_data[8*k +: 8];
    end
  end
`endif

  // A stage can take a beat if it or any stage after it is empty, or the
  // consumer drains this cycle; this collapses bubbles under back-pressure.
  always_comb begin
    stage_ready = '0;
    for (int s = 0; s < STAGES; s++) begin
      stage_ready[s] = bus.out_ready;
      for (int t = s; t < STAGES; t++) begin
        if (!v_q[t]) stage_ready[s] = 1'b1;
      end
    end
  end

  always_comb begin
    src_valid    = '0;
    src_mode     = '0;
    src_valid[0] = bus.in_valid;
    src_mode[0]  = bus.in_mode;
    src_data[0]  = lut_data;
`ifdef AES_SBOX_PARITY_EN
    src_par[0]   = lut_par;
`endif
    for (int s = 1; s < STAGES; s++) begin
      src_valid[s] = v_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_data[s]  = data_q[s-1];
`ifdef AES_SBOX_PARITY_EN
      src_par[s]   = par_q[s-1];
`endif
    end
  end

  always_comb begin
    v_d    = v_q;
    mode_d = mode_q;
    data_d = data_q;
`ifdef AES_SBOX_PARITY_EN
    par_d  = par_q;
`endif
    if (clr) begin
      v_d = '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (stage_ready[s]) begin
          v_d[s] = src_valid[s];
          if (src_valid[s]) begin
            mode_d[s] = src_mode[s];
            data_d[s] = src_data[s];
`ifdef AES_SBOX_PARITY_EN
            par_d[s]  = src_par[s];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      mode_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
`ifdef AES_SBOX_PARITY_EN
        par_q[s]  <= '0;
`endif
      end
    end else begin
      v_q    <= v_d;
      mode_q <= mode_d;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= data_d[s];
`ifdef AES_SBOX_PARITY_EN
        par_q[s]  <= par_d[s];
`endif
      end
    end
  end

  assign bus.in_ready  = stage_ready[0] & ~clr;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out_mode  = mode_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
`ifdef AES_SBOX_PARITY_EN
  assign bus.out_par   = par_q[STAGES-1];
`endif

endmodule

// File: tb/tb_aes_sbox_lane_pipe.sv
// tb/tb_aes_sbox_lane_pipe.sv - randomized scoreboard bench for aes_sbox_lane_pipe
// Reference S-box derived from GF(2^8) inversion plus the affine map.
module tb_aes_sbox_lane_pipe;

  typedef struct packed {
    logic        mode;
    logic [31:0] data;
  } beat_t;

  logic clk;
  logic rst;
  logic clr;

  aes_sbox_lane_pipe_if #(.LANES(4)) bus ();

  aes_sbox_lane_pipe #(.LANES(4), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];
  beat_t tx_q [$];
  beat_t rx_q [$];
  beat_t orig_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, x);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic beat_t ref_beat(input beat_t b);
    beat_t r;
    r.mode = b.mode;
    r.data = '0;
    for (int k = 0; k < 4; k++)
      r.data[8*k +: 8] = b.mode ? ref_inv[b.data[8*k +: 8]] : ref_fwd[b.data[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [3:0] ref_par(input logic [31:0] d);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = ^d[8*k +: 8];
    return p;
  endfunction

  task automatic run_stream(input int rmode);
    beat_t exp_q [$];
    beat_t cur, want;
    logic [31:0] prev_data;
    logic prev_mode, prev_stall;
    int cyc, acc, budget;
    prev_stall = 1'b0; prev_data = '0; prev_mode = 1'b0;
    cyc = 0; acc = 0;
    budget = 40 * tx_q.size() + 50;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      bus.in_valid = (tx_q.size() > 0) && (rmode != 1 || $urandom_range(0, 3) != 0);
      if (tx_q.size() > 0) begin
        bus.in_mode = tx_q[0].mode;
        bus.in_data = tx_q[0].data;
      end
      case (rmode)
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        2:       bus.out_ready = (cyc >= 5);
        default: bus.out_ready = 1'b1;
      endcase
      #1;
      if (prev_stall) begin
        check("stall_data", 64'(bus.out_data), 64'(prev_data));
        check("stall_mode", 64'(bus.out_mode), 64'(prev_mode));
      end
      if (rmode == 2 && cyc == 4) begin
        check("held_beats", 64'(acc), 64'd2);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(tx_q.pop_front());
        acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          cur  = exp_q.pop_front();
          want = ref_beat(cur);
          check("beat_data", 64'(bus.out_data), 64'(want.data));
          check("beat_mode", 64'(bus.out_mode), 64'(want.mode));
`ifdef AES_SBOX_PARITY_EN
          check("beat_par", 64'(bus.out_par), 64'(ref_par(want.data)));
`endif
        end
        rx_q.push_back({bus.out_mode, bus.out_data});
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_mode  = bus.out_mode;
      cyc++;
    end
    check("stream_drained", 64'(tx_q.size() + exp_q.size()), 64'd0);
    tx_q.delete();
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic mode, input logic [31:0] din,
                          input logic [31:0] dexp);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_mode = mode; bus.in_data = din; bus.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check({tag, "_lat_early"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.out_data), 64'(dexp));
    check({tag, "_mode"}, 64'(bus.out_mode), 64'(mode));
`ifdef AES_SBOX_PARITY_EN
    check({tag, "_par"}, 64'(bus.out_par), 64'(ref_par(dexp)));
`endif
  endtask

  task automatic fill_two(input logic mode);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_mode = mode; bus.in_data = $urandom;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    beat_t b;
    logic [31:0] held;
    for (int x = 0; x < 256; x++) ref_fwd[x] = model_sbox(8'(x));
    for (int x = 0; x < 256; x++) ref_inv[ref_fwd[x]] = 8'(x);

    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_mode", 64'(bus.out_mode), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef AES_SBOX_PARITY_EN
    check("rst_out_par", 64'(bus.out_par), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    directed("inv_vec", 1'b1, 32'hff_63_01_00, 32'h7d_00_09_52);
    directed("fwd_vec", 1'b0, 32'hff_53_01_00, 32'h16_ed_7c_63);

    for (int i = 0; i < 150; i++) begin
      b.mode = 1'($urandom_range(0, 1));
      b.data = $urandom;
      tx_q.push_back(b);
    end
    run_stream(1);

    rx_q.delete(); orig_q.delete();
    for (int i = 0; i < 64; i++) begin
      b.mode = 1'b0;
      b.data = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      tx_q.push_back(b);
      orig_q.push_back(b);
    end
    run_stream(0);
    for (int i = 0; i < 64 && rx_q.size() > 0; i++) begin
      b = rx_q.pop_front();
      b.mode = 1'b1;
      tx_q.push_back(b);
    end
    rx_q.delete();
    run_stream(0);
    check("roundtrip_count", 64'(rx_q.size()), 64'd64);
    for (int i = 0; i < 64 && rx_q.size() > 0; i++) begin
      b = rx_q.pop_front();
      check("roundtrip", 64'(b.data), 64'(orig_q[i].data));
    end

    for (int i = 0; i < 8; i++) begin
      b.mode = 1'(i % 2);
      b.data = $urandom;
      tx_q.push_back(b);
    end
    rx_q.delete();
    run_stream(2);
    check("alt_count", 64'(rx_q.size()), 64'd8);
    for (int i = 0; i < 8 && rx_q.size() > 0; i++) begin
      b = rx_q.pop_front();
      check("alt_mode", 64'(b.mode), 64'(i % 2));
    end

    fill_two(1'b1);
    @(negedge clk);
    clr = 1'b1; bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_data = 32'hdead_beef;
    #1;
    check("clr_in_ready", 64'(bus.in_ready), 64'd0);
    check("clr_pipe_full", 64'(bus.out_valid), 64'd1);
    held = bus.out_data;
    @(negedge clk);
    clr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("clr_out_valid", 64'(bus.out_valid), 64'd0);
    check("clr_in_ready_after", 64'(bus.in_ready), 64'd1);
    check("clr_data_kept", 64'(bus.out_data), 64'(held));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("clr_no_refused", 64'(bus.out_valid), 64'd0);
    end

    fill_two(1'b1);
    #1 check("rstmid_pre_valid", 64'(bus.out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstmid_out_data", 64'(bus.out_data), 64'd0);
    check("rstmid_out_mode", 64'(bus.out_mode), 64'd0);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("rstmid_no_output", 64'(bus.out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
